crc24_check: RTL

CRC24_CHECK -- requirements
Module: crc24_check

---
 rtl/crc24_pkg.sv | 18 +
 rtl/crc24_core.sv | 35 +++
 rtl/crc24_check.sv | 128 ++++++++++++
 3 files changed

// File: rtl/crc24_pkg.sv
// Shared widths, CRC polynomial and FSM encoding for the crc24 receive check.
package crc24_pkg;

    localparam int CRC_W        = 24;
    localparam int HDR_BITS_DEF = 40;
    localparam int CNT_W        = 12;
    localparam int ERR_CNT_W    = 16;

    // x^24 + x^10 + x^9 + x^6 + x^4 + x^3 + x + 1, x^24 term implicit
    localparam logic [CRC_W-1:0] CRC_POLY = 24'h00065B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2
    } state_t;

endpackage

// File: rtl/crc24_core.sv
// Serial CRC24 LFSR; the MSB is the first CRC bit on air.
module crc24_core
    import crc24_pkg::*;
#(
    parameter int           W    = CRC_W,
    parameter logic [W-1:0] POLY = W'(CRC_POLY)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] init,
    input  logic         init_load,
    input  logic         data_in,
    input  logic         data_in_valid,
    output logic [W-1:0] lfsr
);

    logic         fb;
    logic [W-1:0] lfsr_step;

    always_comb begin
        fb        = lfsr[W-1] ^ data_in;
        lfsr_step = {lfsr[W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= '0;
        end else if (init_load) begin
            lfsr <= init;
        end else if (data_in_valid) begin
            lfsr <= lfsr_step;
        end
    end

endmodule

// File: rtl/crc24_check.sv
// Receive-side CRC24 check with a 24-bit delay line ahead of the LFSR.
// Define CRC24_CHECK_ERR_CNT_EN to build the saturating failed-check counter.
module crc24_check
    import crc24_pkg::*;
#(
    parameter int CRC_STATE_BIT_WIDTH = CRC_W,
    parameter int HDR_BITS            = HDR_BITS_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CRC_STATE_BIT_WIDTH-1:0] crc_state_init_bit,
    input  logic                           crc_state_init_bit_load,
    input  logic                           info_bit,
    input  logic                           info_bit_valid,
    input  logic                           info_bit_valid_last,
    output logic                           crc_ok,
    output logic                           crc_ok_valid,
    output logic                           len_err,
    output logic [ERR_CNT_W-1:0]           crc_err_cnt
);

    localparam int W = CRC_STATE_BIT_WIDTH;
    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(HDR_BITS + W);

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     sr;
    logic [W-1:0]     lfsr;
    logic [CNT_W-1:0] n;
    logic             accept;
    logic             feed;
    logic             load;
    logic             len_now;
    logic             ok_now;

    always_comb begin
        accept  = info_bit_valid && (state != CHECK);
        feed    = accept && (n >= MIN_LEN);
        load    = crc_state_init_bit_load && (state == IDLE);
        len_now = n < MIN_LEN;
        ok_now  = (sr == lfsr) && !len_now;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (info_bit_valid) begin
                    state_nxt = info_bit_valid_last ? CHECK : RUN;
                end
            end
            RUN: begin
                if (info_bit_valid && info_bit_valid_last) begin
                    state_nxt = CHECK;
                end
            end
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // sr[W-1] lags the input by W bits, so the trailing CRC never reaches the LFSR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
            n  <= '0;
        end else if (state == CHECK) begin
            sr <= '0;
            n  <= '0;
        end else if (accept) begin
            sr <= {sr[W-2:0], info_bit};
            if (n != '1) begin
                n <= n + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_ok       <= 1'b0;
            crc_ok_valid <= 1'b0;
            len_err      <= 1'b0;
        end else begin
            crc_ok_valid <= (state == CHECK);
            if (state == CHECK) begin
                crc_ok  <= ok_now;
                len_err <= len_now;
            end
        end
    end

`ifdef CRC24_CHECK_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if ((state == CHECK) && !ok_now && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign crc_err_cnt = err_cnt;
`else
    assign crc_err_cnt = '0;
`endif

    crc24_core #(
        .W (W)
    ) u_core (
        .clk           (clk),
        .rst           (rst),
        .init          (crc_state_init_bit),
        .init_load     (load),
        .data_in       (sr[W-1]),
        .data_in_valid (feed),
        .lfsr          (lfsr)
    );

endmodule
